// File: rtl/ctle_boost_sweep_ctrl.sv
// CTLE boost-code sweep sequencer: settles each code, counts PRBS errors over a
// fixed sample window, then applies the code with the fewest errors.
module ctle_boost_sweep_ctrl #(
    parameter int unsigned NUM_CODES      = 8,
    parameter int unsigned CODE_W         = 3,
    parameter int unsigned SETTLE_CYCLES  = 64,
    parameter int unsigned WINDOW_SAMPLES = 1024,
    parameter int unsigned ERR_W          = 11,
    parameter int unsigned ERR_THRESH     = 16
) (
    input  logic              CLK,
    input  logic              Rst_n,
    input  logic              start,
    input  logic              err_valid,
    input  logic              err_bit,
    output logic [CODE_W-1:0] boost_code,
    output logic              busy,
    output logic              done,
    output logic [ERR_W-1:0]  best_err_cnt,
    output logic              sweep_fail
);

    localparam int unsigned SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int unsigned SMP_W = (WINDOW_SAMPLES > 1) ? $clog2(WINDOW_SAMPLES) : 1;
    localparam logic [CODE_W-1:0] LAST_CODE = CODE_W'(NUM_CODES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETTLE,
        S_MEASURE,
        S_COMPARE,
        S_APPLY,
        S_DONE
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [SET_W-1:0]   r_settle_cnt;
    logic [SMP_W-1:0]   r_sample_cnt;
    logic [ERR_W-1:0]   r_err_cnt;
    logic [ERR_W-1:0]   r_best;
    logic [CODE_W-1:0]  r_best_code;

    logic w_settle_last;
    logic w_window_last;
    logic w_cmp_stop;

    assign w_settle_last = (r_settle_cnt == SET_W'(SETTLE_CYCLES - 1));
    assign w_window_last = err_valid && (r_sample_cnt == SMP_W'(WINDOW_SAMPLES - 1));
    // A clean window cannot be beaten, so the sweep ends early on zero errors.
    assign w_cmp_stop    = (r_err_cnt == '0) || (boost_code == LAST_CODE);

    always_ff @(posedge CLK or negedge Rst_n) begin
        if (!Rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        busy   = 1'b0;
        done   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) w_next = S_SETTLE;
            end
            S_SETTLE: begin
                busy = 1'b1;
                if (w_settle_last) w_next = S_MEASURE;
            end
            S_MEASURE: begin
                busy = 1'b1;
                if (w_window_last) w_next = S_COMPARE;
            end
            S_COMPARE: begin
                busy   = 1'b1;
                w_next = w_cmp_stop ? S_APPLY : S_SETTLE;
            end
            S_APPLY: begin
                busy   = 1'b1;
                w_next = S_DONE;
            end
            S_DONE: begin
                done = 1'b1;
                if (start) w_next = S_SETTLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge Rst_n) begin
        if (!Rst_n) begin
            boost_code   <= '0;
            best_err_cnt <= '1;
            sweep_fail   <= 1'b0;
            r_settle_cnt <= '0;
            r_sample_cnt <= '0;
            r_err_cnt    <= '0;
            r_best       <= '1;
            r_best_code  <= '0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        boost_code   <= '0;
                        r_best       <= '1;
                        r_best_code  <= '0;
                        r_settle_cnt <= '0;
                    end
                end
                S_SETTLE: begin
                    r_settle_cnt <= r_settle_cnt + SET_W'(1);
                    if (w_settle_last) begin
                        r_err_cnt    <= '0;
                        r_sample_cnt <= '0;
                    end
                end
                S_MEASURE: begin
                    if (err_valid) begin
                        r_sample_cnt <= r_sample_cnt + SMP_W'(1);
                        if (err_bit && (r_err_cnt != '1)) r_err_cnt <= r_err_cnt + ERR_W'(1);
                    end
                end
                S_COMPARE: begin
                    // Strict less-than keeps the lower code on ties.
                    if (r_err_cnt < r_best) begin
                        r_best      <= r_err_cnt;
                        r_best_code <= boost_code;
                    end
                    if (!w_cmp_stop) begin
                        boost_code   <= boost_code + CODE_W'(1);
                        r_settle_cnt <= '0;
                    end
                end
                S_APPLY: begin
                    boost_code   <= r_best_code;
                    best_err_cnt <= r_best;
                    sweep_fail   <= (r_best > ERR_W'(ERR_THRESH));
                end
                default: ;
            endcase
        end
    end

endmodule
